// File: rtl/multi_channel_trigger_if.sv
// Trigger block bus: live configuration and trigger inputs in, trigger status out.
interface multi_channel_trigger_if #(
    parameter int N_CH   = 4,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = 16
) ();
    logic [N_CH-1:0]   Trig_In;
    logic [2*N_CH-1:0] Edge_Sel;
    logic              Trig_EN;
    logic [1:0]        Mode;
    logic [HOLD_W-1:0] Holdoff;
    logic              Trig_Dout;
    logic              Trig_Pulse;
    logic [N_CH-1:0]   Trig_Src;
    logic [CNT_W-1:0]  Trig_Count;
    logic              Holdoff_Busy;

    modport master (
        output Trig_In, Edge_Sel, Trig_EN, Mode, Holdoff,
        input  Trig_Dout, Trig_Pulse, Trig_Src, Trig_Count, Holdoff_Busy
    );

    modport slave (
        input  Trig_In, Edge_Sel, Trig_EN, Mode, Holdoff,
        output Trig_Dout, Trig_Pulse, Trig_Src, Trig_Count, Holdoff_Busy
    );
endinterface

// File: rtl/multi_channel_trigger.sv
// Multi-channel trigger: per-channel edge qualification, merged event,
// holdoff suppression, toggle/pulse/latched output, event count and source.
module multi_channel_trigger #(
    parameter int N_CH   = 4,
    parameter int HOLD_W = 16,
    parameter int CNT_W  = 16
) (
    input logic                   Clock,
    input logic                   Reset,
    multi_channel_trigger_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_TOGGLE     = 2'b00,
        MODE_PULSE      = 2'b01,
        MODE_LATCH      = 2'b10,
        MODE_TOGGLE_ALT = 2'b11
    } mode_e;

    logic [N_CH-1:0]   r_temp;
    logic [N_CH-1:0]   r_hit;
    logic [HOLD_W-1:0] r_hold;
    logic              r_dout;
    logic              r_pulse;
    logic [N_CH-1:0]   r_src;
    logic [CNT_W-1:0]  r_count;

    logic [N_CH-1:0]   w_hit_next;
    logic              w_accept;
    mode_e             w_mode;

    assign w_mode   = mode_e'(bus.Mode);
    assign w_accept = bus.Trig_EN && (|r_hit) && (r_hold == '0);

    // Qualify each channel's transition against its rising/falling enables.
    always_comb begin
        w_hit_next = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_hit_next[i] = (bus.Trig_In[i] & ~r_temp[i] & bus.Edge_Sel[2*i])
                          | (~bus.Trig_In[i] & r_temp[i] & bus.Edge_Sel[2*i+1]);
        end
    end

    // Stage 1: previous-input history and registered hit vector.
    always_ff @(posedge Clock) begin
        if (Reset || !bus.Trig_EN) begin
            r_temp <= '0;
            r_hit  <= '0;
        end else begin
            r_temp <= bus.Trig_In;
            r_hit  <= w_hit_next;
        end
    end

    // Holdoff counter: loaded on accept, counts down to zero otherwise.
    always_ff @(posedge Clock) begin
        if (Reset || !bus.Trig_EN) begin
            r_hold <= '0;
        end else if (w_accept) begin
            r_hold <= bus.Holdoff;
        end else if (r_hold != '0) begin
            r_hold <= r_hold - HOLD_W'(1);
        end
    end

    // Event statistics survive a disable; only reset clears them.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_src   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_src   <= r_hit;
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Output stage: strobe plus mode-dependent trigger level.
    always_ff @(posedge Clock) begin
        if (Reset || !bus.Trig_EN) begin
            r_pulse <= 1'b0;
            r_dout  <= 1'b0;
        end else begin
            r_pulse <= w_accept;
            case (w_mode)
                MODE_PULSE: r_dout <= w_accept;
                MODE_LATCH: begin
                    if (w_accept) begin
                        r_dout <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_dout <= ~r_dout;
                    end
                end
            endcase
        end
    end

    assign bus.Trig_Dout    = r_dout;
    assign bus.Trig_Pulse   = r_pulse;
    assign bus.Trig_Src     = r_src;
    assign bus.Trig_Count   = r_count;
    assign bus.Holdoff_Busy = (r_hold != '0);

endmodule

// File: tb/tb_multi_channel_trigger.sv
// Bench for multi_channel_trigger: directed vectors, a timestamp-based
// reference model checked every cycle, and literal spot checks.
module tb_multi_channel_trigger;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multi_channel_trigger_if #(.N_CH(4), .HOLD_W(16), .CNT_W(16)) bus ();

    multi_channel_trigger #(.N_CH(4), .HOLD_W(16), .CNT_W(16)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: acceptance judged from the edge index of the last
    // accepted event plus the holdoff captured with it.
    int          m_edge     = 0;
    logic [3:0]  m_seen     = '0;
    logic [3:0]  m_pend     = '0;
    bit          m_hv       = 0;
    int          m_last_acc = 0;
    int          m_last_h   = 0;
    logic        m_dout     = 0;
    logic        m_pulse    = 0;
    logic [3:0]  m_src      = '0;
    int unsigned m_count    = 0;
    logic        m_busy     = 0;

    always @(posedge clk) begin
        bit         acc;
        logic [3:0] np;
        m_edge++;
        if (rst || !bus.Trig_EN) begin
            m_seen  = '0;
            m_pend  = '0;
            m_hv    = 0;
            m_dout  = 0;
            m_pulse = 0;
            if (rst) begin
                m_src   = '0;
                m_count = 0;
            end
        end else begin
            acc = (m_pend != 0) && (!m_hv || (m_edge > m_last_acc + m_last_h));
            np = '0;
            for (int c = 0; c < 4; c++) begin
                if (bus.Trig_In[c] && !m_seen[c] && bus.Edge_Sel[2*c])   np[c] = 1'b1;
                if (!bus.Trig_In[c] && m_seen[c] && bus.Edge_Sel[2*c+1]) np[c] = 1'b1;
            end
            m_pulse = acc;
            if (acc) begin
                m_src      = m_pend;
                m_count    = (m_count + 1) % 65536;
                m_hv       = 1;
                m_last_acc = m_edge;
                m_last_h   = int'(bus.Holdoff);
            end
            if (bus.Mode == 2'b01)      m_dout = acc;
            else if (acc && bus.Mode == 2'b10) m_dout = 1'b1;
            else if (acc)               m_dout = ~m_dout;
            m_pend = np;
            m_seen = bus.Trig_In;
        end
        m_busy = m_hv && (m_edge < m_last_acc + m_last_h);
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_edge > 0) begin
            chk("cyc_dout",  bus.Trig_Dout,    m_dout);
            chk("cyc_pulse", bus.Trig_Pulse,   m_pulse);
            chk("cyc_src",   bus.Trig_Src,     m_src);
            chk("cyc_count", bus.Trig_Count,   m_count[15:0]);
            chk("cyc_busy",  bus.Holdoff_Busy, m_busy);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit [7:0] pat;
        rst          = 1'b1;
        bus.Trig_In  = '0;
        bus.Edge_Sel = 8'h01;
        bus.Trig_EN  = 1'b1;
        bus.Mode     = 2'b00;
        bus.Holdoff  = '0;
        cyc(2);
        chk("rst_dout",  bus.Trig_Dout,  0);
        chk("rst_count", bus.Trig_Count, 0);
        chk("rst_src",   bus.Trig_Src,   0);
        rst = 1'b0;
        cyc(2);

        // Toggle mode, ch0 rising, three 5-cycle pulses.
        for (int r = 0; r < 3; r++) begin
            bus.Trig_In = 4'b0001;
            cyc(1);
            if (r == 0) chk("t1_lat_pulse0", bus.Trig_Pulse, 0);
            cyc(1);
            if (r == 0) begin
                chk("t1_lat_pulse1", bus.Trig_Pulse, 1);
                chk("t1_lat_dout",   bus.Trig_Dout,  1);
            end
            cyc(3);
            bus.Trig_In = 4'b0000;
            cyc(5);
        end
        chk("t1_count", bus.Trig_Count, 3);
        chk("t1_src",   bus.Trig_Src,   4'b0001);
        chk("t1_dout",  bus.Trig_Dout,  1);
        chk("t1_model_count", m_count, 3);

        // Pulse mode, ch1 falling + ch2 both edges in the same cycle.
        bus.Edge_Sel = 8'h38;
        bus.Mode     = 2'b01;
        bus.Trig_In  = 4'b0010;
        cyc(3);
        bus.Trig_In = 4'b0100;
        cyc(2);
        chk("t2_pulse", bus.Trig_Pulse, 1);
        chk("t2_src",   bus.Trig_Src,   4'b0110);
        chk("t2_count", bus.Trig_Count, 4);
        chk("t2_dout",  bus.Trig_Dout,  1);
        cyc(1);
        chk("t2_dout_drop", bus.Trig_Dout, 0);
        bus.Holdoff = 16'd10;
        cyc(2);
        bus.Trig_In = 4'b0000;
        cyc(2);
        chk("t2_src2",   bus.Trig_Src,   4'b0100);
        chk("t2_count2", bus.Trig_Count, 5);
        cyc(2);
        chk("t2_busy", bus.Holdoff_Busy, 1);

        // Reset in the middle of holdoff.
        rst = 1'b1;
        cyc(1);
        chk("rst_mid_count", bus.Trig_Count,   0);
        chk("rst_mid_busy",  bus.Holdoff_Busy, 0);
        chk("rst_mid_src",   bus.Trig_Src,     0);
        rst          = 1'b0;
        bus.Holdoff  = '0;
        bus.Edge_Sel = 8'h01;
        bus.Mode     = 2'b00;
        bus.Trig_In  = 4'b0001;
        cyc(2);
        chk("post_rst_count", bus.Trig_Count, 1);
        chk("post_rst_pulse", bus.Trig_Pulse, 1);
        bus.Trig_In = 4'b0000;
        cyc(2);

        // Holdoff 3, ch0 changes at loop edges 0,2,4,5.
        bus.Edge_Sel = 8'h03;
        bus.Holdoff  = 16'd3;
        bus.Mode     = 2'b01;
        cyc(2);
        pat = 8'b0001_0011;
        for (int t = 0; t < 8; t++) begin
            bus.Trig_In[0] = pat[t];
            cyc(1);
            if (t == 1) begin
                chk("t3_acc0_pulse", bus.Trig_Pulse, 1);
                chk("t3_acc0_busy",  bus.Holdoff_Busy, 1);
            end
            if (t == 3) begin
                chk("t3_drop_pulse", bus.Trig_Pulse, 0);
                chk("t3_busy_e3",    bus.Holdoff_Busy, 1);
            end
            if (t == 4) chk("t3_busy_e4", bus.Holdoff_Busy, 0);
            if (t == 5) chk("t3_acc1_pulse", bus.Trig_Pulse, 1);
            if (t == 6) chk("t3_drop2_pulse", bus.Trig_Pulse, 0);
        end
        cyc(6);
        chk("t3_count", bus.Trig_Count, 3);

        // Latched mode, then a one-cycle disable.
        bus.Mode    = 2'b10;
        bus.Holdoff = '0;
        for (int k = 0; k < 4; k++) begin
            bus.Trig_In[0] = ~bus.Trig_In[0];
            cyc(2);
            chk("t4_dout_hi", bus.Trig_Dout, 1);
            cyc(1);
        end
        chk("t4_count", bus.Trig_Count, 7);
        bus.Trig_EN = 1'b0;
        cyc(1);
        chk("t4_dis_dout",  bus.Trig_Dout,  0);
        chk("t4_dis_count", bus.Trig_Count, 7);
        bus.Trig_EN = 1'b1;
        cyc(2);

        // Re-enable with ch0 already high.
        bus.Mode     = 2'b00;
        bus.Edge_Sel = 8'h01;
        bus.Trig_EN  = 1'b0;
        bus.Trig_In  = 4'b0001;
        cyc(3);
        bus.Trig_EN = 1'b1;
        cyc(1);
        chk("t5_en_pulse0", bus.Trig_Pulse, 0);
        cyc(1);
        chk("t5_en_pulse1", bus.Trig_Pulse, 1);
        chk("t5_en_count",  bus.Trig_Count, 8);
        cyc(2);
        bus.Trig_EN = 1'b0;
        cyc(2);
        bus.Edge_Sel = 8'h02;
        bus.Trig_EN  = 1'b1;
        cyc(4);
        chk("t5_fall_count", bus.Trig_Count, 8);
        chk("t5_fall_dout",  bus.Trig_Dout,  0);

        // Back-to-back events with no holdoff up to counter wrap.
        bus.Edge_Sel = 8'h03;
        for (int k = 0; k < 65527; k++) begin
            bus.Trig_In[0] = ~bus.Trig_In[0];
            cyc(1);
        end
        cyc(3);
        chk("wrap_ffff", bus.Trig_Count, 16'hFFFF);
        chk("wrap_model_ffff", m_count, 32'h0000FFFF);
        bus.Trig_In[0] = ~bus.Trig_In[0];
        cyc(2);
        chk("wrap_0000", bus.Trig_Count, 16'h0000);
        chk("wrap_pulse", bus.Trig_Pulse, 1);
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_trigger.md
# multi_channel_trigger

Parametrised successor to the two-input normal trigger in the AFG trigger path. It accepts N_CH trigger inputs, each with a per-channel edge selection (rising, falling, both or off), and merges the qualified edges into one trigger event. A programmable holdoff window suppresses retriggering. The output runs in toggle (legacy), pulse or latched mode, and the block reports an event counter and the source mask of the last event. It sits between the external/internal trigger synchronisers and the waveform sequencer start logic.

## Interface
- N_CH, 4, number of trigger inputs (1..16)
- HOLD_W, 16, holdoff counter width
- CNT_W, 16, event counter width
- Clock  in  1  single system clock, all logic on posedge
- Reset  in  1  synchronous, active-high; overrides Trig_EN
- Trig_In  in  N_CH  already-synchronised trigger inputs
- Edge_Sel  in  2*N_CH  per channel i bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- Trig_EN  in  1  block enable; low = clear pipeline/output as in legacy trigger
- Mode  in  2  00 toggle, 01 pulse, 10 latched, 11 treated as 00
- Holdoff  in  HOLD_W  cycles of suppression after an accepted event; 0 = none
- Trig_Dout  out  1  trigger output per Mode
- Trig_Pulse  out  1  one-cycle strobe per accepted event, all modes
- Trig_Src  out  N_CH  channel hit mask of last accepted event
- Trig_Count  out  CNT_W  accepted-event count, wraps
- Holdoff_Busy  out  1  high while holdoff counter nonzero

## Operation
- Stage 1, per channel: Temp[i] <= Trig_In[i]; Hit[i] <= (Trig_In[i] & ~Temp[i] & rising_en[i]) | (~Trig_In[i] & Temp[i] & falling_en[i]).
- Event = |Hit (registered vector).
- Stage 2: event accepted iff Event=1 and hold_cnt==0. Events during holdoff are dropped, not queued.
- On accept:
  - Trig_Pulse<=1; Trig_Src<=Hit; Trig_Count<=Trig_Count+1 (mod 2^CNT_W); hold_cnt<=Holdoff.
  - Mode 00: Trig_Dout<=~Trig_Dout.
  - Mode 01: Trig_Dout<=1 for one cycle.
  - Mode 10: Trig_Dout<=1 and stays high.
- No accept:
  - Trig_Pulse<=0.
  - Mode 01: Trig_Dout<=0. Modes 00/10: Trig_Dout holds.
  - hold_cnt decrements if nonzero.
- Mode change takes effect at the next edge; the accumulated toggle/latched level is not altered except that entering mode 01 drives Trig_Dout to 0 absent an event.
- Trig_EN=0:
  - Temp, Hit, hold_cnt, Trig_Dout and Trig_Pulse are all cleared.
  - Trig_Count and Trig_Src hold.
  - On re-enable with an input already high and rising enabled, a rising edge is detected (Temp starts at 0); no falling edge is detected.
- Reset: all registers and outputs to 0, including Trig_Count and Trig_Src.
- Edge_Sel and Holdoff are sampled live each cycle. A changed Holdoff affects only the next load.

## Timing
- Input first seen high before posedge k -> Hit set at k -> Trig_Dout/Trig_Pulse/Trig_Count update at k+1. Latency is 2 edges.
- Holdoff=H, event accepted at edge a: events at edges a+1..a+H are dropped; the earliest next accept is at edge a+H+1.
- Holdoff_Busy is high for cycles after edges a..a+H-1 (H cycles).
- Simultaneous hits on several channels count as one event; Trig_Src shows all of them.
- Back-to-back hits with H=0 are accepted every cycle; toggle mode then toggles every cycle.
- Reset mid-holdoff clears hold_cnt; the next event is accepted normally.

## Test plan
- N_CH=4, Edge_Sel=0x01, Mode 00, H=0: pulse Trig_In[0] high 5 cycles, 3 times -> Trig_Dout toggles 3 times, each 2 edges after the rising input; Trig_Count=3; Trig_Src=0001.
- Edge_Sel ch1=10, ch2=11, Mode 01: drive ch1 1->0 and ch2 0->1 in the same cycle -> one Trig_Pulse, Trig_Src=0110, Trig_Count+1; then ch2 1->0 -> second pulse, Trig_Src=0100.
- Holdoff=3, ch0 rising events at cycles 0, 2, 4, 5 -> accepts at 0 and 4 only; 2 and 5 dropped; Holdoff_Busy high 3 cycles after each accept; Trig_Count=2.
- Mode 10: one event -> Trig_Dout=1 and stays high through 3 further events; Trig_EN low 1 cycle -> Trig_Dout=0, Trig_Count retained.
- Trig_EN low while ch0 held high, then re-enabled with Edge_Sel=01 -> one event accepted 2 edges after enable; with Edge_Sel=10 -> no event.
- Reset asserted mid-holdoff with Trig_Count=0x0005 -> all outputs 0 next edge; a count starting at 0xFFFF wraps to 0x0000 on the next accept.
